// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the elastic pipeline stage: occupancy state encoding and
// a helper that maps a state onto its held-beat count.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    case (s)
      PS_BUSY: return 2'd1;
      PS_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Reusable elastic pipeline register with valid/ready flow control, an
// optional 2-entry skid buffer (registered ready) and synchronous flush.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int SKID          = 1,
  parameter int ZERO_ON_FLUSH = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              s_valid_in,
  output logic              s_ready_out,
  input  logic [DATA_W-1:0] s_data_in,
  output logic              m_valid_out,
  input  logic              m_ready_in,
  output logic [DATA_W-1:0] m_data_out,
  output logic [1:0]        occ_out
);

  logic w_accept;
  logic w_consume;

  assign w_accept  = s_valid_in && s_ready_out;
  assign w_consume = m_valid_out && m_ready_in;

  if (SKID != 0) begin : g_skid
    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic              r_ready;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    // Ready is registered from the next state so m_ready_in never reaches s_ready_out.
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_state <= PS_EMPTY;
        r_ready <= 1'b1;
      end else begin
        r_state <= w_state_nxt;
        r_ready <= (w_state_nxt != PS_FULL);
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      if (flush_in) begin
        w_state_nxt = PS_EMPTY;
      end else begin
        case (r_state)
          PS_EMPTY: if (w_accept) w_state_nxt = PS_BUSY;
          PS_BUSY: begin
            if (w_accept && !w_consume)      w_state_nxt = PS_FULL;
            else if (!w_accept && w_consume) w_state_nxt = PS_EMPTY;
          end
          PS_FULL:  if (w_consume) w_state_nxt = PS_BUSY;
          default:  w_state_nxt = PS_EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_main <= '0;
        r_skid <= '0;
      end else if (flush_in) begin
        if (ZERO_ON_FLUSH != 0) begin
          r_main <= '0;
          r_skid <= '0;
        end
      end else begin
        case (r_state)
          PS_EMPTY: if (w_accept) r_main <= s_data_in;
          PS_BUSY: begin
            if (w_accept && w_consume) r_main <= s_data_in;
            else if (w_accept)         r_skid <= s_data_in;
          end
          PS_FULL:  if (w_consume) r_main <= r_skid;
          default: ;
        endcase
      end
    end

    always_comb begin
      m_valid_out = (r_state != PS_EMPTY);
      m_data_out  = r_main;
      occ_out     = occ_of(r_state);
      s_ready_out = r_ready;
    end
  end else begin : g_single
    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_main;

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) r_state <= PS_EMPTY;
      else         r_state <= w_state_nxt;
    end

    // In BUSY an accept implies a same-cycle consume, so the stage stays BUSY.
    always_comb begin
      w_state_nxt = r_state;
      if (flush_in)                      w_state_nxt = PS_EMPTY;
      else if (w_accept)                 w_state_nxt = PS_BUSY;
      else if (w_consume)                w_state_nxt = PS_EMPTY;
      else if (r_state == PS_FULL)       w_state_nxt = PS_EMPTY;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_main <= '0;
      end else if (flush_in) begin
        if (ZERO_ON_FLUSH != 0) r_main <= '0;
      end else if (w_accept) begin
        r_main <= s_data_in;
      end
    end

    always_comb begin
      m_valid_out = (r_state != PS_EMPTY);
      m_data_out  = r_main;
      occ_out     = occ_of(r_state);
      s_ready_out = (r_state == PS_EMPTY) || m_ready_in;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three configurations driven by shared stimulus,
// each compared every cycle against a FIFO-style behavioural model.
module tb_pipe_stage_skid;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          s_valid;
  logic          m_ready;
  logic [DW-1:0] s_data;

  logic          s_ready [3];
  logic          m_valid [3];
  logic [DW-1:0] m_data  [3];
  logic [1:0]    occ     [3];

  int n_checks = 0;
  int n_fail   = 0;

  int            mdl_cnt  [3];
  logic [DW-1:0] mdl_q    [3][2];
  logic [DW-1:0] mdl_disp [3];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .ZERO_ON_FLUSH(1)) u_skid (
    .clk_in(clk), .rst_in(rst_n), .flush_in(flush),
    .s_valid_in(s_valid), .s_ready_out(s_ready[0]), .s_data_in(s_data),
    .m_valid_out(m_valid[0]), .m_ready_in(m_ready), .m_data_out(m_data[0]),
    .occ_out(occ[0]));

  pipe_stage_skid #(.DATA_W(DW), .SKID(0), .ZERO_ON_FLUSH(1)) u_single (
    .clk_in(clk), .rst_in(rst_n), .flush_in(flush),
    .s_valid_in(s_valid), .s_ready_out(s_ready[1]), .s_data_in(s_data),
    .m_valid_out(m_valid[1]), .m_ready_in(m_ready), .m_data_out(m_data[1]),
    .occ_out(occ[1]));

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .ZERO_ON_FLUSH(0)) u_keep (
    .clk_in(clk), .rst_in(rst_n), .flush_in(flush),
    .s_valid_in(s_valid), .s_ready_out(s_ready[2]), .s_data_in(s_data),
    .m_valid_out(m_valid[2]), .m_ready_in(m_ready), .m_data_out(m_data[2]),
    .occ_out(occ[2]));

  function automatic bit is_skid(input int i);
    return i != 1;
  endfunction

  function automatic bit is_zof(input int i);
    return i != 2;
  endfunction

  function automatic logic mdl_ready(input int i);
    if (is_skid(i)) return mdl_cnt[i] < 2;
    return (mdl_cnt[i] == 0) || m_ready;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 3; i++) begin
      mdl_cnt[i]  = 0;
      mdl_disp[i] = '0;
      mdl_q[i][0] = '0;
      mdl_q[i][1] = '0;
    end
  endtask

  // One rising edge of the reference: pop on consume, push on accept.
  task automatic mdl_edge();
    for (int i = 0; i < 3; i++) begin
      logic rdy, cons, acc;
      rdy  = mdl_ready(i);
      cons = (mdl_cnt[i] > 0) && m_ready;
      acc  = s_valid && rdy;
      if (flush) begin
        mdl_cnt[i] = 0;
        if (is_zof(i)) mdl_disp[i] = '0;
      end else begin
        if (cons) begin
          mdl_q[i][0] = mdl_q[i][1];
          mdl_cnt[i]--;
        end
        if (acc) begin
          mdl_q[i][mdl_cnt[i]] = s_data;
          mdl_cnt[i]++;
        end
        if (mdl_cnt[i] > 0) mdl_disp[i] = mdl_q[i][0];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("valid[%0d]", i), DW'(m_valid[i]), DW'(mdl_cnt[i] > 0));
      check($sformatf("data[%0d]", i),  m_data[i],       mdl_disp[i]);
      check($sformatf("occ[%0d]", i),   DW'(occ[i]),     DW'(mdl_cnt[i]));
      check($sformatf("ready[%0d]", i), DW'(s_ready[i]), DW'(mdl_ready(i)));
    end
  endtask

  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    @(negedge clk);
    check_all();
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    mdl_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back stream
    step(1'b1, 32'h11, 1'b1, 1'b0);
    check("stream_first", m_data[0], 32'h11);
    step(1'b1, 32'h22, 1'b1, 1'b0);
    step(1'b1, 32'h33, 1'b1, 1'b0);
    check("stream_last", m_data[0], 32'h33);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure fills the skid entry
    step(1'b1, 32'hA0, 1'b1, 1'b0);
    step(1'b1, 32'hA1, 1'b0, 1'b0);
    check("stall_occ", DW'(occ[0]), 32'd2);
    check("stall_ready", DW'(s_ready[0]), 32'd0);
    check("stall_hold", m_data[0], 32'hA0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_a1", m_data[0], 32'hA1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while FULL with a beat offered
    step(1'b1, 32'hB0, 1'b0, 1'b0);
    step(1'b1, 32'hB1, 1'b0, 1'b0);
    step(1'b1, 32'hB2, 1'b0, 1'b1);
    check("flush_valid", DW'(m_valid[0]), 32'd0);
    check("flush_zero", m_data[0], 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush without zeroing keeps the payload visible
    step(1'b1, 32'hC5, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("keep_valid", DW'(m_valid[2]), 32'd0);
    check("keep_data", m_data[2], 32'hC5);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while FULL
    step(1'b1, 32'hD0, 1'b0, 1'b0);
    step(1'b1, 32'hD1, 1'b0, 1'b0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", DW'(m_valid[0]), 32'd0);
    check("arst_occ", DW'(occ[0]), 32'd0);
    check("arst_data", m_data[0], 32'h0);
    check("arst_ready", DW'(s_ready[0]), 32'd1);
    mdl_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Random traffic with occasional flush
    for (int n = 0; n < 1000; n++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 49) == 0));
    end
    for (int n = 0; n < 4; n++) step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline-stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable elastic stage.
- Carries an opaque payload of DATA_W bits (packed control vector plus datapath fields) with valid/ready flow control, a 2-entry skid buffer for full throughput under backpressure, and a synchronous flush for branch/exception squash.
- Sits between any two pipeline stages; hazard logic drives flush_in and stalls through m_ready_in.

Parameters:
- DATA_W, 32, payload width in bits; must be >= 1.
- SKID, 1, 1 = 2-entry skid mode with registered s_ready_out; 0 = single-entry mode with combinational ready (s_ready_out = !m_valid_out || m_ready_in).
- ZERO_ON_FLUSH, 1, 1 = payload registers cleared to 0 on flush; 0 = only valid bits cleared.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- flush_in  input  1  synchronous squash of all held and incoming beats.
- s_valid_in  input  1  upstream beat valid.
- s_ready_out  output  1  stage can accept a beat this cycle.
- s_data_in  input  DATA_W  upstream payload.
- m_valid_out  output  1  downstream beat valid.
- m_ready_in  input  1  downstream accepts (0 = stall).
- m_data_out  output  DATA_W  downstream payload; always driven from a register.
- occ_out  output  2  number of held beats (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Handshakes: input accepted when s_valid_in && s_ready_out; output consumed when m_valid_out && m_ready_in.
- Ordering: strictly in-order; no beat duplicated or dropped except by flush.
- Reset (rst_in=0, async):
  - State EMPTY, all payload registers 0.
  - m_valid_out=0, occ_out=0.
  - s_ready_out=1 in both modes.
- States (SKID=1), where main = output register and skid = overflow register:
  - EMPTY, occ 0, s_ready 1:
    - accept -> BUSY.
  - BUSY, occ 1, s_ready 1:
    - accept & consume -> BUSY; main loads new beat.
    - accept & !consume -> FULL; beat goes to skid.
    - !accept & consume -> EMPTY.
    - otherwise hold.
  - FULL, occ 2, s_ready 0:
    - consume -> BUSY; skid moves to main.
    - otherwise hold.
- s_ready_out (SKID=1) is a register output equal to (next_state != FULL); no combinational path from m_ready_in.
- SKID=0: only EMPTY/BUSY are used. In BUSY, accept & consume gives back-to-back throughput. s_ready_out is combinational from m_ready_in.
- Latency: an accepted beat appears on m_data_out/m_valid_out the cycle after acceptance when the stage is EMPTY, or when it is BUSY and consumed in the same cycle.
- Throughput: 1 beat/cycle sustained whenever m_ready_in=1.
- Payload holds stable while m_valid_out=1 && m_ready_in=0.
- Flush (flush_in=1 at a rising edge) has priority over every other event:
  - Next state EMPTY, occ_out=0, m_valid_out=0.
  - A beat handshaken in the same cycle is discarded.
  - A beat consumed downstream in the same cycle counts as delivered.
  - If ZERO_ON_FLUSH=1, main and skid payloads become 0; otherwise they keep their old values.
  - s_ready_out=1 the cycle after flush.
- Reset mid-stream: all held beats lost immediately (async); no output glitch back to valid after release.
- Upstream must not change s_data_in while s_valid_in=1 && s_ready_out=0. The stage does not check this.
- No X propagation: m_data_out is deterministic from reset onward.

Decomposition:
- riscv_types package: add typedef enum logic [1:0] pipe_state_t {PS_EMPTY, PS_BUSY, PS_FULL}.
- Stage payloads stay as existing packed structs (riscv_control_t plus fields), packed into DATA_W at instantiation.
- One generate branch per SKID value.
- No sub-module; the main/skid registers are simple enough inline.

Test Plan:
- Reset, then stream 0x11, 0x22, 0x33 with m_ready_in=1 -> m_data_out shows 0x11, 0x22, 0x33 on consecutive cycles starting 1 cycle after the first accept; occ_out=1 throughout; s_ready_out stays 1.
- BUSY with 0xA0, m_ready_in=0, push 0xA1 -> occ_out=2, s_ready_out=0 next cycle, m_data_out holds 0xA0. Raise m_ready_in -> 0xA0 then 0xA1 delivered; s_ready_out=1 one cycle after the first consume.
- FULL (0xB0, 0xB1), flush_in=1 together with s_valid_in=1 carrying 0xB2 -> next cycle m_valid_out=0, occ_out=0, m_data_out=0 (ZERO_ON_FLUSH=1); 0xB2 never appears.
- ZERO_ON_FLUSH=0, flush while holding 0xC5 -> m_valid_out=0, m_data_out still 0xC5.
- Assert rst_in=0 mid-cycle while FULL -> outputs go to 0 immediately, without waiting for a clock edge; after release, s_ready_out=1 and m_valid_out=0.
- SKID=0, random s_valid_in/m_ready_in over 1000 cycles, scoreboard -> in-order, lossless; occ_out ≤ 1; s_ready_out == !m_valid_out || m_ready_in every cycle.
